// File: rtl/credit_bp_link.sv
// Credit-gated NoC link endpoint pair: DVR -> credited link flits (tx), link flits -> per-VC FIFOs -> DVR (rx).
// Latency: tx accept -> link_o_v next cycle; link_i_v -> rx_o_v next cycle; pop -> link_o_credit next cycle.
// Backpressure: tx_o_b from zero credits or a lower VC winning this cycle; rx side obeys rx_i_b, overflow drops and flags.
//
// Ports:
//   clk, rst (async active-low)
//   tx_i_v/tx_i_d/tx_o_b          local sender, per-VC valid + shared flit + per-VC backpressure
//   link_o_v/link_o_d             outgoing link flit (one-hot valid), registered
//   link_i_credit                 credit returns from the far receiver
//   link_i_v/link_i_d             incoming link flit
//   link_o_credit                 credit returns to the far transmitter, one pulse per pop
//   rx_o_v/rx_o_d/rx_i_b          per-VC head flit to the local consumer with its backpressure
//   rx_err                        sticky: FIFO overflow or credit overflow

// Generic single-clock FIFO with N usable entries and a combinational head.
// Latency: push visible at the head one cycle later; pop retires the head at the edge.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and reported on ovf.
module cbl_fifo #(
    parameter int W = 8,
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic         head_vld,
    output logic [W-1:0] head_dat,
    output logic         ovf
);
    localparam int PW   = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW = $clog2(N + 1);

    logic [W-1:0]    mem [N];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] cnt;
    logic            full, do_push, do_pop;

    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign full     = (cnt == CNTW'(N));
    assign do_pop   = pop_vld && head_vld;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign do_push  = push_vld && (!full || do_pop);
    assign ovf      = push_vld && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(N - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(N - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Credit-based VC-aware flow-control endpoint pair.
// Latency: one registered stage on each of tx flit, rx head availability and credit return.
// Backpressure: tx per-VC by credits and lowest-index arbitration; rx per-VC via rx_i_b.
module credit_bp_link #(
    parameter  int VC_W  = 2,
    parameter  int D_W   = 32,
    parameter  int A_W   = 8,
    parameter  int DEPTH = 4,
    localparam int W     = A_W + D_W + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [VC_W-1:0]           tx_i_v,
    input  logic [W-1:0]              tx_i_d,
    output logic [VC_W-1:0]           tx_o_b,
    output logic [VC_W-1:0]           link_o_v,
    output logic [W-1:0]              link_o_d,
    input  logic [VC_W-1:0]           link_i_credit,
    input  logic [VC_W-1:0]           link_i_v,
    input  logic [W-1:0]              link_i_d,
    output logic [VC_W-1:0]           link_o_credit,
    output logic [VC_W-1:0]           rx_o_v,
    output logic [VC_W-1:0][W-1:0]    rx_o_d,
    input  logic [VC_W-1:0]           rx_i_b,
    output logic                      rx_err
);
    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CMAX = CW'(DEPTH - 1);

    logic [CW-1:0]   credit [VC_W];
    logic [VC_W-1:0] acc;
    logic [VC_W-1:0] cr_ovf;
    logic [VC_W-1:0] pop;
    logic [VC_W-1:0] fifo_ovf;
    logic            seen;

    // Lowest-index arbitration: once a VC wins, every higher VC sees backpressure.
    always_comb begin
        acc    = '0;
        tx_o_b = '0;
        seen   = 1'b0;
        for (int v = 0; v < VC_W; v++) begin
            tx_o_b[v] = (credit[v] == '0) || seen;
            if (tx_i_v[v] && (credit[v] != '0) && !seen) begin
                acc[v] = 1'b1;
                seen   = 1'b1;
            end
        end
    end

    // A credit arriving with the counter already full means the far end returned more than it got.
    always_comb begin
        cr_ovf = '0;
        for (int v = 0; v < VC_W; v++)
            cr_ovf[v] = link_i_credit[v] && (credit[v] == CMAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_W; v++) credit[v] <= CMAX;
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                if (link_i_credit[v] && !acc[v])
                    credit[v] <= (credit[v] == CMAX) ? CMAX : credit[v] + 1'b1;
                else if (acc[v] && !link_i_credit[v])
                    credit[v] <= credit[v] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link_o_v      <= '0;
            link_o_d      <= '0;
            link_o_credit <= '0;
            rx_err        <= 1'b0;
        end else begin
            link_o_v      <= acc;
            if (|acc) link_o_d <= tx_i_d;
            link_o_credit <= pop;
            rx_err        <= rx_err | (|cr_ovf) | (|fifo_ovf);
        end
    end

    assign pop = rx_o_v & ~rx_i_b;

    for (genvar v = 0; v < VC_W; v++) begin : g_vc
        cbl_fifo #(
            .W (W),
            .N (DEPTH - 1)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push_vld (link_i_v[v]),
            .push_dat (link_i_d),
            .pop_vld  (pop[v]),
            .head_vld (rx_o_v[v]),
            .head_dat (rx_o_d[v]),
            .ovf      (fifo_ovf[v])
        );
    end
endmodule

// File: tb/tb_credit_bp_link.sv
module tb_credit_bp_link;
    localparam int VC_W  = 2;
    localparam int D_W   = 32;
    localparam int A_W   = 8;
    localparam int DEPTH = 4;
    localparam int W     = A_W + D_W + 1;

    logic                   clk, rst;
    logic [VC_W-1:0]        tx_i_v, tx_o_b, link_o_v, link_i_credit, link_i_v, link_o_credit;
    logic [VC_W-1:0]        rx_o_v, rx_i_b;
    logic [W-1:0]           tx_i_d, link_o_d, link_i_d;
    logic [VC_W-1:0][W-1:0] rx_o_d;
    logic                   rx_err;

    // Link side is either looped back or driven directly by the bench.
    logic                   loop;
    logic [VC_W-1:0]        drv_v, drv_cr;
    logic [W-1:0]           drv_d;
    assign link_i_v      = loop ? link_o_v      : drv_v;
    assign link_i_d      = loop ? link_o_d      : drv_d;
    assign link_i_credit = loop ? link_o_credit : drv_cr;

    credit_bp_link #(.VC_W(VC_W), .D_W(D_W), .A_W(A_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .tx_i_v(tx_i_v), .tx_i_d(tx_i_d), .tx_o_b(tx_o_b),
        .link_o_v(link_o_v), .link_o_d(link_o_d),
        .link_i_credit(link_i_credit), .link_i_v(link_i_v), .link_i_d(link_i_d),
        .link_o_credit(link_o_credit),
        .rx_o_v(rx_o_v), .rx_o_d(rx_o_d), .rx_i_b(rx_i_b), .rx_err(rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: credit counts, FIFO contents as arrays, expected registered outputs.
    int              mcred [VC_W];
    int              mcnt  [VC_W];
    logic [W-1:0]    mfifo [VC_W][DEPTH];
    logic [VC_W-1:0] m_lv, m_lc;
    logic [W-1:0]    m_ld;
    logic            m_err;

    // Observation of the DUT's VC0 pops for the directed ordering check.
    logic            log_en = 1'b0;
    logic [W-1:0]    got0 [$];
    int              cr0_cnt;

    task automatic model_reset();
        for (int v = 0; v < VC_W; v++) begin
            mcred[v] = DEPTH - 1;
            mcnt[v]  = 0;
        end
        m_lv  = '0;
        m_lc  = '0;
        m_ld  = '0;
        m_err = 1'b0;
    endtask

    function automatic int winner();
        int w = -1;
        for (int v = 0; v < VC_W; v++)
            if (w < 0 && tx_i_v[v] && mcred[v] > 0) w = v;
        return w;
    endfunction

    task automatic check_cycle();
        int              w;
        logic [VC_W-1:0] eb, ev;
        w  = winner();
        eb = '0;
        ev = '0;
        for (int v = 0; v < VC_W; v++) begin
            eb[v] = (mcred[v] == 0) || (w >= 0 && w < v);
            ev[v] = (mcnt[v] > 0);
        end
        chk("tx_o_b", 64'(tx_o_b), 64'(eb));
        chk("link_o_v", 64'(link_o_v), 64'(m_lv));
        chk("link_o_d", 64'(link_o_d), 64'(m_ld));
        chk("link_o_credit", 64'(link_o_credit), 64'(m_lc));
        chk("rx_o_v", 64'(rx_o_v), 64'(ev));
        chk("rx_err", 64'(rx_err), 64'(m_err));
        for (int v = 0; v < VC_W; v++)
            if (mcnt[v] > 0) chk("rx_o_d", 64'(rx_o_d[v]), 64'(mfifo[v][0]));
        if (log_en && rx_o_v[0] && !rx_i_b[0]) got0.push_back(rx_o_d[0]);
        if (log_en && link_o_credit[0]) cr0_cnt++;
    endtask

    task automatic model_step();
        int              w;
        logic [VC_W-1:0] li_v, li_cr, nlc;
        logic [W-1:0]    li_d;
        li_v  = loop ? m_lv : drv_v;
        li_d  = loop ? m_ld : drv_d;
        li_cr = loop ? m_lc : drv_cr;
        w     = winner();
        nlc   = '0;
        for (int v = 0; v < VC_W; v++) begin
            if (li_cr[v] && mcred[v] == DEPTH - 1) m_err = 1'b1;
            mcred[v] = mcred[v] - ((w == v) ? 1 : 0) + (li_cr[v] ? 1 : 0);
            if (mcred[v] > DEPTH - 1) mcred[v] = DEPTH - 1;
            if (mcnt[v] > 0 && !rx_i_b[v]) begin
                nlc[v] = 1'b1;
                for (int k = 0; k < DEPTH - 1; k++) mfifo[v][k] = mfifo[v][k+1];
                mcnt[v]--;
            end
            if (li_v[v]) begin
                if (mcnt[v] < DEPTH - 1) begin
                    mfifo[v][mcnt[v]] = li_d;
                    mcnt[v]++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        m_lv = (w >= 0) ? VC_W'(1 << w) : '0;
        if (w >= 0) m_ld = tx_i_d;
        m_lc = nlc;
    endtask

    // Compare process: late in each cycle, after stimulus has settled, before the next rising edge.
    always begin
        @(negedge clk);
        #3;
        if (!rst) model_reset();
        check_cycle();
        if (rst) model_step();
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tx_i_v = '0; tx_i_d = '0; rx_i_b = '0;
        drv_v = '0; drv_d = '0; drv_cr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    logic [VC_W-1:0] rem, ob;
    int              ok;

    initial begin
        rst = 1'b0; loop = 1'b1;
        tx_i_v = '0; tx_i_d = '0; rx_i_b = '0;
        drv_v = '0; drv_d = '0; drv_cr = '0;
        model_reset();

        // 1: reset values
        @(negedge clk); #2;
        chk("rst link_o_v", 64'(link_o_v), 64'h0);
        chk("rst rx_o_v", 64'(rx_o_v), 64'h0);
        chk("rst link_o_credit", 64'(link_o_credit), 64'h0);
        chk("rst tx_o_b", 64'(tx_o_b), 64'h0);
        chk("rst rx_err", 64'(rx_err), 64'h0);
        chk("model rst credit", 64'(mcred[0]), 64'd3);
        @(negedge clk); rst = 1'b1;

        // 2: loopback, VC0 consumer blocked
        @(negedge clk); rx_i_b = 2'b01; tx_i_v = 2'b01; tx_i_d = W'(5);
        @(negedge clk); tx_i_d = W'(6);
        @(negedge clk); tx_i_d = W'(7);
        @(negedge clk); tx_i_d = W'(8); #2;
        chk("t2 tx_o_b exhausted", 64'(tx_o_b), 64'h1);
        chk("t2 head", 64'(rx_o_d[0]), 64'd5);
        chk("model t2 credit0", 64'(mcred[0]), 64'd0);
        @(negedge clk); #2;
        chk("t2 tx_o_b held", 64'(tx_o_b), 64'h1);

        // 3: VC1 unaffected while VC0 is stuck
        @(negedge clk); tx_i_v = 2'b10; tx_i_d = W'(9); #2;
        chk("t3 tx_o_b", 64'(tx_o_b), 64'h1);
        @(negedge clk); tx_i_v = 2'b00; #2;
        chk("t3 link_o_v", 64'(link_o_v), 64'h2);
        chk("t3 link_o_d", 64'(link_o_d), 64'd9);
        @(negedge clk); #2;
        chk("t3 rx_o_d1", 64'(rx_o_d[1]), 64'd9);

        // 2 (cont.): release VC0, flit 8 goes once credits return
        got0.delete(); cr0_cnt = 0; log_en = 1'b1;
        @(negedge clk); tx_i_v = 2'b01; tx_i_d = W'(8); rx_i_b = 2'b00; #2;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            if (!tx_o_b[0]) ok = 1;
            else begin @(negedge clk); #2; end
        end
        chk("t2 flit 8 accepted", 64'(ok), 64'd1);
        @(negedge clk); tx_i_v = 2'b00;
        repeat (12) @(negedge clk);
        log_en = 1'b0;
        chk("t2 credit pulses", 64'(cr0_cnt), 64'd4);
        chk("t2 pop count", 64'(got0.size()), 64'd4);
        for (int i = 0; i < 4 && i < got0.size(); i++)
            chk("t2 pop order", 64'(got0[i]), 64'(5 + i));

        // 4: credit arriving alongside a blocked request
        do_reset(); loop = 1'b0;
        @(negedge clk); tx_i_v = 2'b01; tx_i_d = W'(1);
        @(negedge clk); tx_i_d = W'(2);
        @(negedge clk); tx_i_d = W'(3);
        @(negedge clk); tx_i_d = W'(4); #2;
        chk("t4 blocked", 64'(tx_o_b[0]), 64'h1);
        chk("model t4 credit0", 64'(mcred[0]), 64'd0);
        @(negedge clk); drv_cr = 2'b01; #2;
        chk("t4 still blocked", 64'(tx_o_b), 64'h1);
        @(negedge clk); drv_cr = 2'b00; #2;
        chk("t4 unblocked", 64'(tx_o_b[0]), 64'h0);
        @(negedge clk); tx_i_v = 2'b00; #2;
        chk("t4 link_o_v", 64'(link_o_v), 64'h1);
        chk("t4 link_o_d", 64'(link_o_d), 64'd4);
        chk("t4 credit gone", 64'(tx_o_b[0]), 64'h1);
        @(negedge clk); drv_cr = 2'b01;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); drv_cr = 2'b00;

        // 5: both VCs request at once
        @(negedge clk); tx_i_v = 2'b11; tx_i_d = W'(10); #2;
        chk("t5 tx_o_b", 64'(tx_o_b), 64'h2);
        @(negedge clk); tx_i_v = 2'b10; #2;
        chk("t5 vc0 out", 64'(link_o_v), 64'h1);
        chk("t5 vc1 free", 64'(tx_o_b), 64'h0);
        @(negedge clk); tx_i_v = 2'b00; #2;
        chk("t5 vc1 out", 64'(link_o_v), 64'h2);
        @(negedge clk); drv_cr = 2'b11;
        @(negedge clk); drv_cr = 2'b00;

        // 6: overflow of a blocked receive FIFO
        @(negedge clk); rx_i_b = 2'b01; drv_v = 2'b01; drv_d = W'(256);
        @(negedge clk); drv_d = W'(257);
        @(negedge clk); drv_d = W'(258);
        @(negedge clk); drv_d = W'(259); #2;
        chk("t6 no err yet", 64'(rx_err), 64'h0);
        @(negedge clk); drv_v = 2'b00; #2;
        chk("t6 err set", 64'(rx_err), 64'h1);
        chk("t6 head", 64'(rx_o_d[0]), 64'd256);
        chk("model t6 err", 64'(m_err), 64'h1);
        @(negedge clk); rx_i_b = 2'b00;
        repeat (5) @(negedge clk);
        #2;
        chk("t6 err sticky", 64'(rx_err), 64'h1);
        chk("t6 drained", 64'(rx_o_v), 64'h0);
        @(negedge clk); rst = 1'b0; #2;
        chk("t6 err cleared", 64'(rx_err), 64'h0);

        // Random loopback traffic with sender hold discipline
        do_reset(); loop = 1'b1;
        rem = '0; ob = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rem = tx_i_v & ob;
            if (rem != '0) begin
                tx_i_v = rem;
            end else begin
                tx_i_v = VC_W'($urandom_range(0, 3));
                tx_i_d = W'({$urandom, $urandom});
            end
            rx_i_b = ($urandom_range(0, 3) == 0) ? 2'b11 : VC_W'($urandom_range(0, 3));
            #2;
            ob = tx_o_b;
        end
        @(negedge clk); tx_i_v = '0; rx_i_b = '0;
        repeat (20) @(negedge clk);
        #2;
        chk("rand no err", 64'(rx_err), 64'h0);
        chk("rand credits home", 64'(mcred[0] + mcred[1]), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
